// File: rtl/cache_refill_ctrl.sv
// Read-side refill controller for the direct-mapped data cache: tag lookup,
// miss fetch over a req/ack memory handshake, bank fill and full-cache flush.
module cache_refill_ctrl #(
    parameter int unsigned INDEX_W = 10,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [31:0]       cpu_addr,
    input  logic              flush,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,
    output logic              busy,
    input  logic              hit,
    input  logic [31:0]       cache_rdata,
    output logic [31:0]       bank_addr,
    output logic              bank_write,
    output logic              bank_valid,
    output logic [31:0]       bank_wdata,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_COMPARE = 3'd2,
        ST_MEM_REQ = 3'd3,
        ST_FILL    = 3'd4,
        ST_DONE    = 3'd5,
        ST_FLUSH   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr_q;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [DATA_W-1:0]  r_data_q;
    logic [DATA_W-1:0]  w_data_nxt;
    logic [DATA_W-1:0]  r_rdata_hold;
    logic [DATA_W-1:0]  w_rdata_nxt;
    logic [INDEX_W-1:0] r_idx;
    logic [INDEX_W-1:0] w_idx_nxt;
    logic [CNT_W-1:0]   r_miss_cnt;
    logic [CNT_W-1:0]   w_miss_nxt;

    assign miss_count = r_miss_cnt;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_addr_q     <= '0;
            r_data_q     <= '0;
            r_rdata_hold <= '0;
            r_idx        <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr_q     <= w_addr_nxt;
            r_data_q     <= w_data_nxt;
            r_rdata_hold <= w_rdata_nxt;
            r_idx        <= w_idx_nxt;
            r_miss_cnt   <= w_miss_nxt;
        end
    end

    // Next-state and state-decoded outputs; hit data is returned in COMPARE itself.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr_q;
        w_data_nxt  = r_data_q;
        w_rdata_nxt = r_rdata_hold;
        w_idx_nxt   = r_idx;
        w_miss_nxt  = r_miss_cnt;
        cpu_ready   = 1'b0;
        cpu_rdata   = r_rdata_hold;
        busy        = 1'b1;
        bank_addr   = '0;
        bank_write  = 1'b0;
        bank_valid  = 1'b0;
        bank_wdata  = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (flush) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_FLUSH;
                end else if (cpu_req) begin
                    w_addr_nxt  = cpu_addr;
                    w_state_nxt = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                bank_addr   = r_addr_q;
                w_state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                bank_addr = r_addr_q;
                if (hit) begin
                    cpu_ready   = 1'b1;
                    cpu_rdata   = cache_rdata;
                    w_rdata_nxt = cache_rdata;
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (r_miss_cnt != {CNT_W{1'b1}}) begin
                        w_miss_nxt = r_miss_cnt + CNT_W'(1);
                    end
                    w_state_nxt = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {r_addr_q[ADDR_W-1:2], 2'b00};
                if (mem_ack) begin
                    w_data_nxt  = mem_rdata;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                bank_write  = 1'b1;
                bank_valid  = 1'b1;
                bank_addr   = r_addr_q;
                bank_wdata  = r_data_q;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                cpu_ready   = 1'b1;
                cpu_rdata   = r_data_q;
                w_rdata_nxt = r_data_q;
                w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                bank_write = 1'b1;
                bank_valid = 1'b0;
                bank_addr  = ADDR_W'({r_idx, 2'b00});
                w_idx_nxt  = r_idx + INDEX_W'(1);
                if (&r_idx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a behavioural data bank and a
// memory responder whose ack latency is set per load.
module tb_cache_refill_ctrl;

    localparam int unsigned INDEX_W = 10;
    localparam int unsigned CNT_W   = 3;

    logic             clock;
    logic             reset;
    logic             cpu_req;
    logic [31:0]      cpu_addr;
    logic             flush;
    logic             cpu_ready;
    logic [31:0]      cpu_rdata;
    logic             busy;
    logic             hit;
    logic [31:0]      cache_rdata;
    logic [31:0]      bank_addr;
    logic             bank_write;
    logic             bank_valid;
    logic [31:0]      bank_wdata;
    logic             mem_req;
    logic [31:0]      mem_addr;
    logic             mem_ack;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] miss_count;

    cache_refill_ctrl #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .flush       (flush),
        .cpu_ready   (cpu_ready),
        .cpu_rdata   (cpu_rdata),
        .busy        (busy),
        .hit         (hit),
        .cache_rdata (cache_rdata),
        .bank_addr   (bank_addr),
        .bank_write  (bank_write),
        .bank_valid  (bank_valid),
        .bank_wdata  (bank_wdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .miss_count  (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data bank: tag/valid/data arrays, read result one cycle after the address.
    logic [1023:0] bank_v;
    logic [19:0]   bank_tag [1024];
    logic [31:0]   bank_d   [1024];
    logic [9:0]    w_bidx;
    assign w_bidx = bank_addr[11:2];

    always @(posedge clock) begin
        if (!reset) begin
            bank_v <= '0;
        end else if (bank_write) begin
            bank_v[w_bidx]   <= bank_valid;
            bank_tag[w_bidx] <= bank_addr[31:12];
            bank_d[w_bidx]   <= bank_wdata;
        end
        hit         <= bank_v[w_bidx] && (bank_tag[w_bidx] == bank_addr[31:12]);
        cache_rdata <= bank_d[w_bidx];
    end

    // Bus monitor and memory responder, both on the falling edge.
    int          mem_wait;
    logic [31:0] mem_data;
    logic        spur_ack;
    int          mem_cnt;
    int          req_cnt;
    int          wr_v0;
    int          wr_v1;
    int          wr_v0_at_req;
    logic        prev_req;
    logic [31:0] last_mem_addr;
    logic [31:0] last_fill_addr;
    logic [31:0] last_fill_data;
    logic [31:0] last_flush_addr;

    initial begin
        mem_cnt = 0; req_cnt = 0; wr_v0 = 0; wr_v1 = 0; wr_v0_at_req = 0;
        prev_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        last_mem_addr = '0; last_fill_addr = '0; last_fill_data = '0; last_flush_addr = '0;
    end

    always @(negedge clock) begin
        if (bank_write) begin
            if (bank_valid) begin
                wr_v1++;
                last_fill_addr = bank_addr;
                last_fill_data = bank_wdata;
            end else begin
                wr_v0++;
                last_flush_addr = bank_addr;
            end
        end
        if (mem_req && !prev_req) begin
            req_cnt++;
            last_mem_addr = mem_addr;
            wr_v0_at_req  = wr_v0;
        end
        prev_req = mem_req;
        if (mem_req) begin
            mem_ack   = (mem_cnt == mem_wait);
            mem_rdata = mem_ack ? mem_data : 32'h0BAD_F00D;
            mem_cnt++;
        end else begin
            mem_ack   = spur_ack;
            mem_rdata = 32'h5555_AAAA;
            mem_cnt   = 0;
        end
    end

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one load from IDLE; lat counts clock edges from the sampling edge.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input int w,
                           output int lat, output logic [31:0] rd);
        logic done;
        mem_wait = w;
        mem_data = d;
        done     = 1'b0;
        rd       = '0;
        @(negedge clock);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clock);
        lat = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (cpu_ready) begin
                rd   = cpu_rdata;
                done = 1'b1;
                break;
            end
            @(posedge clock);
            lat++;
        end
        cpu_req = 1'b0;
        if (!done) check_eq("load_timeout", 32'(done), 32'd1);
    endtask

    int          lat;
    logic [31:0] rd;
    int          req_b;
    int          v0_b;
    int          v1_b;
    logic        done;

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
        spur_ack = 1'b0; mem_wait = 0; mem_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_outs", {29'd0, cpu_ready, mem_req, bank_write}, 32'd0);
        check_eq("rst_miss", 32'(miss_count), 32'd0);
        reset = 1'b1;

        // Reset asserted while waiting on memory.
        mem_wait = 1000; mem_data = 32'h1111_2222;
        @(negedge clock);
        cpu_req = 1'b1; cpu_addr = 32'h0000_5678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_req) break;
        end
        cpu_req = 1'b0;
        check_eq("rst_memreq_before", 32'(mem_req), 32'd1);
        check_eq("rst_miss_before", 32'(miss_count), 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_async_memreq", 32'(mem_req), 32'd0);
        check_eq("rst_async_busy", 32'(busy), 32'd0);
        check_eq("rst_async_miss", 32'(miss_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check_eq("rst_release_busy", 32'(busy), 32'd0);
        check_eq("rst_release_miss", 32'(miss_count), 32'd0);

        // Cold miss with three wait cycles, then a hit on the same address.
        req_b = req_cnt; v1_b = wr_v1;
        do_load(32'h0000_1234, 32'hDEAD_BEEF, 3, lat, rd);
        check_eq("cold_rdata", rd, 32'hDEAD_BEEF);
        check_eq("cold_latency", 32'(lat), 32'd8);
        check_eq("cold_req_count", 32'(req_cnt - req_b), 32'd1);
        check_eq("cold_mem_addr", last_mem_addr, 32'h0000_1234);
        check_eq("cold_fill_count", 32'(wr_v1 - v1_b), 32'd1);
        check_eq("cold_fill_index", 32'(last_fill_addr[11:2]), 32'h08D);
        check_eq("cold_fill_data", last_fill_data, 32'hDEAD_BEEF);
        check_eq("cold_miss", 32'(miss_count), 32'd1);

        req_b = req_cnt;
        do_load(32'h0000_1234, 32'h0BAD_0BAD, 0, lat, rd);
        check_eq("hit_rdata", rd, 32'hDEAD_BEEF);
        check_eq("hit_latency", 32'(lat), 32'd2);
        check_eq("hit_no_req", 32'(req_cnt - req_b), 32'd0);
        check_eq("hit_miss", 32'(miss_count), 32'd1);

        // Fill index 5, flush, then reload that address.
        do_load(32'hABCD_E014, 32'hCAFE_F00D, 1, lat, rd);
        check_eq("idx5_rdata", rd, 32'hCAFE_F00D);
        check_eq("idx5_latency", 32'(lat), 32'd6);
        do_load(32'hABCD_E014, 32'h0BAD_0BAD, 0, lat, rd);
        check_eq("idx5_hit_latency", 32'(lat), 32'd2);
        check_eq("idx5_hit_rdata", rd, 32'hCAFE_F00D);
        v0_b = wr_v0;
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clock);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("flush_done", 32'(done), 32'd1);
        check_eq("flush_writes", 32'(wr_v0 - v0_b), 32'd1024);
        check_eq("flush_last_addr", last_flush_addr, 32'h0000_0FFC);
        do_load(32'hABCD_E014, 32'h7777_8888, 0, lat, rd);
        check_eq("reload_rdata", rd, 32'h7777_8888);
        check_eq("reload_latency", 32'(lat), 32'd5);
        check_eq("reload_miss", 32'(miss_count), 32'd3);

        // Flush and load together: flush completes before the load is fetched.
        v0_b = wr_v0; req_b = req_cnt;
        mem_wait = 2; mem_data = 32'h2468_ACE0;
        @(negedge clock);
        flush = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h0000_1234;
        @(negedge clock);
        flush = 1'b0;
        done = 1'b0; rd = '0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clock);
            if (cpu_ready) begin
                rd   = cpu_rdata;
                done = 1'b1;
                break;
            end
        end
        cpu_req = 1'b0;
        check_eq("simul_done", 32'(done), 32'd1);
        check_eq("simul_flush_first", 32'(wr_v0_at_req - v0_b), 32'd1024);
        check_eq("simul_req_count", 32'(req_cnt - req_b), 32'd1);
        check_eq("simul_rdata", rd, 32'h2468_ACE0);
        check_eq("simul_miss", 32'(miss_count), 32'd4);

        // Ack in the first request cycle; then a stray ack while idle.
        do_load(32'h0000_2000, 32'h1357_9BDF, 0, lat, rd);
        check_eq("imm_latency", 32'(lat), 32'd5);
        check_eq("imm_rdata", rd, 32'h1357_9BDF);
        check_eq("imm_miss", 32'(miss_count), 32'd5);
        req_b = req_cnt;
        @(negedge clock); spur_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check_eq("spur_busy", 32'(busy), 32'd0);
        end
        spur_ack = 1'b0;
        @(negedge clock);
        check_eq("spur_no_req", 32'(req_cnt - req_b), 32'd0);
        check_eq("spur_rdata_held", cpu_rdata, 32'h1357_9BDF);
        check_eq("spur_miss", 32'(miss_count), 32'd5);

        // Miss counter runs into its all-ones ceiling.
        do_load(32'h0001_0000, 32'hA1A1_0001, 0, lat, rd);
        check_eq("sat1_miss", 32'(miss_count), 32'd6);
        do_load(32'h0002_0000, 32'hA2A2_0002, 0, lat, rd);
        check_eq("sat2_miss", 32'(miss_count), 32'd7);
        do_load(32'h0003_0000, 32'hA3A3_0003, 0, lat, rd);
        check_eq("sat3_miss", 32'(miss_count), 32'd7);
        check_eq("sat3_rdata", rd, 32'hA3A3_0003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Read-side controller for the direct-mapped data cache. Accepts CPU load requests, performs the tag/valid lookup through the data bank, and on a miss fetches the word from main memory over a req/ack handshake. It then writes the tag, valid bit and data back into the bank and returns the word to the CPU. It also performs a full-cache invalidate (flush) by walking every index and clearing its valid bit.

## Interface

Parameters:
- `INDEX_W`, 10: index width, taken from address bits [11:2].
- `CNT_W`, 16: width of the miss counter.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-low.
- `cpu_req`  in  1: load request; held high until `cpu_ready`.
- `cpu_addr`  in  32: load byte address; stable while `cpu_req` is high.
- `flush`  in  1: one-cycle pulse; invalidate the whole cache.
- `cpu_ready`  out  1: one-cycle pulse; `cpu_rdata` is valid in that cycle.
- `cpu_rdata`  out  32: returned load data.
- `busy`  out  1: high in every state except IDLE.
- `hit`  in  1: data bank hit, valid one cycle after `bank_addr` is presented.
- `cache_rdata`  in  32: cache data word, same timing as `hit`.
- `bank_addr`  out  32: address to the tag, valid and data RAMs.
- `bank_write`  out  1: write strobe to the bank.
- `bank_valid`  out  1: valid bit written when `bank_write` is high.
- `bank_wdata`  out  32: data word written when `bank_write` is high.
- `mem_req`  out  1: memory read request.
- `mem_addr`  out  32: word-aligned memory address.
- `mem_ack`  in  1: memory acknowledge; `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  32: memory read data.
- `miss_count`  out  CNT_W: saturating count of read misses.

## Operation

States: IDLE, LOOKUP, COMPARE, MEM_REQ, FILL, DONE, FLUSH.

- **IDLE**
  - If `flush` is high: go to FLUSH and clear the flush index. Flush wins over a simultaneous `cpu_req`.
  - Else if `cpu_req` is high: latch `cpu_addr` into `addr_q` and go to LOOKUP.
- **LOOKUP:** `bank_addr` = `addr_q`. Go to COMPARE.
- **COMPARE:** `bank_addr` = `addr_q`; sample `hit`.
  - Hit: `cpu_ready`=1, `cpu_rdata` = `cache_rdata`, go to IDLE.
  - Miss: increment `miss_count` (saturating at all-ones), go to MEM_REQ.
- **MEM_REQ:** `mem_req`=1, `mem_addr` = {`addr_q`[31:2], 2'b00}.
  - Hold until `mem_ack`=1.
  - In the ack cycle, latch `mem_rdata` into `data_q` and go to FILL. `mem_req` is low from the next cycle.
- **FILL:** `bank_write`=1, `bank_valid`=1, `bank_addr` = `addr_q`, `bank_wdata` = `data_q`. One cycle, then go to DONE.
- **DONE:** `cpu_ready`=1, `cpu_rdata` = `data_q`. Go to IDLE.
- **FLUSH:**
  - Each cycle: `bank_write`=1, `bank_valid`=0, `bank_addr` = {20'b0, idx, 2'b00}, then idx+1.
  - After idx = 1023 has been written, go to IDLE.
- Outputs are driven only in the states listed above:
  - `mem_req`, `bank_write` and `cpu_ready` are 0 elsewhere.
  - `bank_addr` is 0 in IDLE.
  - `cpu_rdata` holds its last value.
- `flush` pulses outside IDLE are ignored and not queued. `cpu_req` is not re-sampled until the next IDLE.

## Timing

- **Reset (`reset`=0, asynchronous, any state including mid-handshake):**
  - State goes to IDLE; all outputs go to 0 immediately; `miss_count`, `addr_q`, `data_q` and idx are cleared.
  - `mem_req` drops without waiting for `mem_ack`.
- **Hit latency:** `cpu_req` sampled at edge T; LOOKUP during T..T+1; `cpu_ready` high during T+1..T+2 (COMPARE). Next request can be sampled at edge T+2.
- **Miss latency:** `cpu_ready` in the cycle 2 cycles after the `mem_ack` cycle. With ack in the first MEM_REQ cycle, that is 5 cycles from the sampling edge.
- **`mem_ack` outside MEM_REQ:** ignored.
- **Flush:** exactly 1024 consecutive `bank_write` cycles, then `busy` falls.
- **`miss_count`:** updates on the edge leaving COMPARE on a miss. At 16'hFFFF it stays 16'hFFFF.

## Test plan

- **Reset:** assert `reset`=0 mid-MEM_REQ -> `mem_req`=0 and `busy`=0 the same cycle; after release, IDLE with `miss_count`=0.
- **Cold miss then hit:**
  - Load 0x0000_1234 with memory returning 0xDEADBEEF after 3 wait cycles -> one `mem_req` to 0x0000_1234, one FILL write with index 0x08D and `bank_valid`=1, `cpu_rdata`=0xDEADBEEF, `miss_count`=1.
  - Repeat the load -> hit, `cpu_ready` 2 cycles after the request, no `mem_req`.
- **Flush:** fill index 5, pulse `flush` -> exactly 1024 writes with `bank_valid`=0. Reload the index-5 address -> miss, `miss_count` increments.
- **Simultaneous flush and `cpu_req` in IDLE:** flush runs first; `cpu_req` is serviced after `busy` falls.
- **Immediate ack:** `mem_ack` in the first MEM_REQ cycle -> `cpu_ready` 5 cycles after the sampling edge. A spurious `mem_ack` in IDLE has no effect.
- **Counter saturation:** force `miss_count` to 0xFFFE, run 3 misses -> reads 0xFFFF.
